// File: rtl/bounce_generator_if.sv
// Command/observation bundle between the bounce stimulus and the bounce generator.
// The master drives the command level; the slave returns the bouncing contact and window status.
interface bounce_generator_if;
    logic enable;
    logic press;
    logic noisy;
    logic busy;
    logic settled;

    modport master (output enable, output press, input noisy, input busy, input settled);
    modport slave  (input enable, input press, output noisy, output busy, output settled);
endinterface

// File: rtl/bounce_generator.sv
// Contact-bounce model: each accepted press edge yields a pseudo-random burst of
// BOUNCE_CYCLES samples, then noisy settles on the new level with a one-cycle settled pulse.
module bounce_generator #(
    parameter int          BOUNCE_CYCLES = 8,
    parameter int          CNT_W         = 4,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    bounce_generator_if.slave bus
);

    localparam logic [15:0]      SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BOUNCE_CYCLES - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, BOUNCE = 1'b1} state_t;

    state_t           state_r;
    logic [15:0]      lfsr_r;
    logic [CNT_W-1:0] cnt_r;
    logic             tgt_r;
    logic             noisy_r;
    logic             busy_r;
    logic             settled_r;
    logic             press_edge_s;

    // Taps 16,14,13,11 of the right-shifting Fibonacci form; new bit enters at the top.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic fb;
        fb = v[0] ^ v[2] ^ v[3] ^ v[5];
        return {fb, v[15:1]};
    endfunction

    assign press_edge_s = bus.press ^ tgt_r;

    assign bus.noisy   = noisy_r;
    assign bus.busy    = busy_r;
    assign bus.settled = settled_r;

    // Window sequencer: LFSR free-runs, enable only matters while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            lfsr_r    <= SEED_EFF;
            cnt_r     <= {CNT_W{1'b0}};
            tgt_r     <= 1'b0;
            noisy_r   <= 1'b0;
            busy_r    <= 1'b0;
            settled_r <= 1'b0;
        end else begin
            lfsr_r    <= lfsr_next(lfsr_r);
            settled_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.enable) begin
                        if (press_edge_s) begin
                            // First sample of a window always moves toward the new level.
                            tgt_r   <= bus.press;
                            noisy_r <= bus.press;
                            cnt_r   <= CNT_LOAD;
                            busy_r  <= 1'b1;
                            state_r <= BOUNCE;
                        end else begin
                            noisy_r <= noisy_r;
                        end
                    end else begin
                        noisy_r <= bus.press;
                        tgt_r   <= bus.press;
                    end
                end
                BOUNCE: begin
                    if (press_edge_s) begin
                        // A re-press abandons the old window without a settled pulse.
                        tgt_r   <= bus.press;
                        noisy_r <= bus.press;
                        cnt_r   <= CNT_LOAD;
                    end else if (cnt_r != {CNT_W{1'b0}}) begin
                        noisy_r <= lfsr_r[0];
                        cnt_r   <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        noisy_r   <= tgt_r;
                        busy_r    <= 1'b0;
                        settled_r <= 1'b1;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bounce_generator.sv
// Directed, table-driven bench for bounce_generator with an independent LFSR reference.
module tb_bounce_generator;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reset1 = 1'b1;

    bounce_generator_if bif ();
    bounce_generator_if bif1 ();

    bounce_generator #(.BOUNCE_CYCLES(8), .CNT_W(4), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .reset(reset), .bus(bif.slave)
    );

    bounce_generator #(.BOUNCE_CYCLES(1), .CNT_W(4), .LFSR_SEED(16'h0000)) dut1 (
        .clk(clk), .reset(reset1), .bus(bif1.slave)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic       press;
        logic [1:0] n;   // 0/1 literal level, 2 = reference LFSR bit
        logic       b;
        logic       s;
    } vec_t;

    localparam logic [1:0] L = 2'd2;

    vec_t        vq[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_lfsr = 16'hACE1;

    task automatic add(input logic rst, input logic en, input logic press,
                       input logic [1:0] n, input logic b, input logic s);
        vec_t v;
        v.rst = rst; v.en = en; v.press = press; v.n = n; v.b = b; v.s = s;
        vq.push_back(v);
    endtask

    task automatic add_n(input int cnt, input logic rst, input logic en, input logic press,
                         input logic [1:0] n, input logic b, input logic s);
        for (int j = 0; j < cnt; j++) add(rst, en, press, n, b, s);
    endtask

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_step(input logic [15:0] v);
        logic [15:0] bitv;
        bitv = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 16'h0001;
        return (v >> 1) | (bitv << 15);
    endfunction

    initial begin
        logic [15:0] pre;
        logic        expn;
        bit          pat[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        bif.enable = 1'b1;  bif.press = 1'b0;
        bif1.enable = 1'b1; bif1.press = 1'b0;

        // reset held 100 ns
        add_n(5, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        // rising press: window of 8, settle on 9th edge
        add(1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);
        add_n(7, 1'b0, 1'b1, 1'b1, L, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1);
        add_n(2, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
        // falling press mirror
        add(1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
        add_n(7, 1'b0, 1'b1, 1'b0, L, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        // re-press at k+3 restarts the window, settle at k+11
        add(1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);
        add_n(2, 1'b0, 1'b1, 1'b1, L, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
        add_n(7, 1'b0, 1'b1, 1'b0, L, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        // enable low: noisy is press delayed one cycle
        foreach (pat[i]) add(1'b0, 1'b0, pat[i], {1'b0, pat[i]}, 1'b0, 1'b0);
        // enable dropped mid-window does not shorten it
        add(1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);
        add_n(7, 1'b0, 1'b0, 1'b1, L, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        // reset at k+4 aborts the window, then a fresh window
        add(1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);
        add_n(3, 1'b0, 1'b1, 1'b1, L, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);
        add_n(7, 1'b0, 1'b1, 1'b1, L, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            reset = vq[i].rst; bif.enable = vq[i].en; bif.press = vq[i].press;
            pre = m_lfsr;
            @(posedge clk);
            #1;
            m_lfsr = vq[i].rst ? 16'hACE1 : ref_step(m_lfsr);
            expn = (vq[i].n == L) ? pre[0] : vq[i].n[0];
            chk("noisy", i, {15'd0, bif.noisy}, {15'd0, expn});
            chk("busy", i, {15'd0, bif.busy}, {15'd0, vq[i].b});
            chk("settled", i, {15'd0, bif.settled}, {15'd0, vq[i].s});
            if (vq[i].rst) chk("lfsr_seed", i, dut.lfsr_r, 16'hACE1);
        end

        // single-cycle window, zero seed replaced by 1
        @(negedge clk); reset1 = 1'b1; bif1.press = 1'b0;
        @(posedge clk); #1;
        chk("w1_seed", 0, dut1.lfsr_r, 16'h0001);
        chk("w1_rst_noisy", 0, {15'd0, bif1.noisy}, 16'd0);
        @(negedge clk); reset1 = 1'b0; bif1.press = 1'b1;
        @(posedge clk); #1;
        chk("w1_noisy_k", 1, {15'd0, bif1.noisy}, 16'd1);
        chk("w1_busy_k", 1, {15'd0, bif1.busy}, 16'd1);
        chk("w1_settled_k", 1, {15'd0, bif1.settled}, 16'd0);
        @(posedge clk); #1;
        chk("w1_noisy_k1", 2, {15'd0, bif1.noisy}, 16'd1);
        chk("w1_busy_k1", 2, {15'd0, bif1.busy}, 16'd0);
        chk("w1_settled_k1", 2, {15'd0, bif1.settled}, 16'd1);
        @(posedge clk); #1;
        chk("w1_settled_k2", 3, {15'd0, bif1.settled}, 16'd0);
        chk("w1_noisy_k2", 3, {15'd0, bif1.noisy}, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
